// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch and
// load/store data; data wins by default, a starvation counter forces fetch through.
module mem_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              I_REQ,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic [DATA_W-1:0] I_RDATA,
  output logic              I_VALID,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  input  logic [3:0]        D_BE,
  output logic [DATA_W-1:0] D_RDATA,
  output logic              D_VALID,
  output logic              M_EN,
  output logic              M_WE,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [DATA_W-1:0] M_WDATA,
  output logic [3:0]        M_BE,
  input  logic [DATA_W-1:0] M_RDATA,
  output logic              BUSY,
  output logic              OWNER,
  output logic [1:0]        DBG_STATE,
  output logic [3:0]        DBG_STARVE
);

  // Handshake: a requester raises REQ (level) with its address/data stable in
  // the IDLE cycle it is sampled; the access completes with a one-cycle VALID.
  // REQ is only looked at in IDLE, so dropping it early still completes the
  // access and holding it through RESP issues a fresh request.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [3:0] LAT_M1     = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  logic [3:0] wait_cnt;
  logic [3:0] starve_cnt;
  logic       xfer_store;
  logic       grant_data;

  // Data wins a tie unless fetch has already lost STARVE_MAX times in a row.
  always_comb begin
    grant_data = D_REQ && !(I_REQ && (starve_cnt == STARVE_LIM));
  end

  assign DBG_STATE  = state;
  assign DBG_STARVE = starve_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      xfer_store <= 1'b0;
      I_RDATA    <= '0;
      I_VALID    <= 1'b0;
      D_RDATA    <= '0;
      D_VALID    <= 1'b0;
      M_EN       <= 1'b0;
      M_WE       <= 1'b0;
      M_ADDR     <= '0;
      M_WDATA    <= '0;
      M_BE       <= '0;
      BUSY       <= 1'b0;
      OWNER      <= 1'b0;
    end else begin
      I_VALID <= 1'b0;
      D_VALID <= 1'b0;
      M_EN    <= 1'b0;
      M_WE    <= 1'b0;
      M_ADDR  <= '0;
      M_WDATA <= '0;
      M_BE    <= '0;
      unique case (state)
        S_IDLE: begin
          if (I_REQ && grant_data) begin
            starve_cnt <= (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 4'd1;
          end else begin
            starve_cnt <= '0;
          end
          if (I_REQ || D_REQ) begin
            state      <= S_ISSUE;
            BUSY       <= 1'b1;
            OWNER      <= grant_data;
            xfer_store <= grant_data & D_WE;
            M_EN       <= 1'b1;
            // The winner's request is captured straight into the memory-side
            // registers, which then present it during the ISSUE cycle.
            if (grant_data) begin
              M_WE    <= D_WE;
              M_ADDR  <= D_ADDR;
              M_WDATA <= D_WDATA;
              M_BE    <= D_BE;
            end else begin
              M_WE    <= 1'b0;
              M_ADDR  <= I_ADDR;
              M_WDATA <= '0;
              M_BE    <= 4'hF;
            end
          end
        end
        S_ISSUE: begin
          state    <= S_WAIT;
          wait_cnt <= LAT_M1;
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= S_RESP;
            if (OWNER) begin
              if (!xfer_store) begin
                D_RDATA <= M_RDATA;
              end
              D_VALID <= 1'b1;
            end else begin
              I_RDATA <= M_RDATA;
              I_VALID <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
          OWNER <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one MEM_LAT=2 system for the main
// scenarios plus MEM_LAT=1 and MEM_LAT=5 systems for the latency check.
module tb_mem_port_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst   = 1'b1;
  logic a_rst = 1'b1;

  // ---------------- stimulus signals ----------------
  logic        i_req = 1'b0;
  logic [11:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [11:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        a_req = 1'b0;
  logic [11:0] a_addr = '0;

  logic        pl_we = 1'b0;
  int          pl_sel = 0;
  logic [11:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  // ---------------- per-system DUT outputs ----------------
  logic [31:0] ird [3];
  logic        iv [3];
  logic [31:0] drd [3];
  logic        dv [3];
  logic        m_en [3];
  logic        m_we [3];
  logic [11:0] m_addr [3];
  logic [31:0] m_wdata [3];
  logic [3:0]  m_be [3];
  logic [31:0] m_rdata [3];
  logic        busy_v [3];
  logic        owner_v [3];
  logic [1:0]  dbg_state_v [3];
  logic [3:0]  dbg_starve_v [3];

  for (genvar g = 0; g < 3; g++) begin : g_sys
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
    logic [31:0] mem [4096];
    logic [31:0] pipe [L];

    // Fixed-latency memory: read data appears L cycles after the issue cycle.
    always @(posedge clk) begin
      if (pl_we && pl_sel == g) begin
        mem[pl_addr] <= pl_data;
      end else if (m_en[g] && m_we[g]) begin
        for (int b = 0; b < 4; b++) begin
          if (m_be[g][b]) mem[m_addr[g]][8*b +: 8] <= m_wdata[g][8*b +: 8];
        end
      end
      pipe[0] <= m_en[g] ? mem[m_addr[g]] : 32'hA5A5_A5A5;
      for (int s = 1; s < L; s++) pipe[s] <= pipe[s-1];
    end
    assign m_rdata[g] = pipe[L-1];

    mem_port_arbiter #(
      .ADDR_W(12), .DATA_W(32), .MEM_LAT(L), .STARVE_MAX(4)
    ) u_dut (
      .CLK       (clk),
      .RST       (g == 0 ? rst : a_rst),
      .I_REQ     (g == 0 ? i_req : a_req),
      .I_ADDR    (g == 0 ? i_addr : a_addr),
      .I_RDATA   (ird[g]),
      .I_VALID   (iv[g]),
      .D_REQ     (g == 0 ? d_req : 1'b0),
      .D_WE      (g == 0 ? d_we : 1'b0),
      .D_ADDR    (g == 0 ? d_addr : 12'h0),
      .D_WDATA   (g == 0 ? d_wdata : 32'h0),
      .D_BE      (g == 0 ? d_be : 4'h0),
      .D_RDATA   (drd[g]),
      .D_VALID   (dv[g]),
      .M_EN      (m_en[g]),
      .M_WE      (m_we[g]),
      .M_ADDR    (m_addr[g]),
      .M_WDATA   (m_wdata[g]),
      .M_BE      (m_be[g]),
      .M_RDATA   (m_rdata[g]),
      .BUSY      (busy_v[g]),
      .OWNER     (owner_v[g]),
      .DBG_STATE (dbg_state_v[g]),
      .DBG_STARVE(dbg_starve_v[g])
    );
  end

  logic        i_valid, d_valid, busy, owner;
  logic [31:0] i_rdata, d_rdata;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_starve;
  assign i_valid    = iv[0];
  assign d_valid    = dv[0];
  assign i_rdata    = ird[0];
  assign d_rdata    = drd[0];
  assign busy       = busy_v[0];
  assign owner      = owner_v[0];
  assign dbg_state  = dbg_state_v[0];
  assign dbg_starve = dbg_starve_v[0];

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];  // {is_data, rdata expected at VALID}

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (i_valid === 1'b1 || d_valid === 1'b1) begin
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL resp_unexpected observed=valid(i=%0b d=%0b) expected=none", i_valid, d_valid);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("resp_side", {63'b0, d_valid}, {63'b0, e[32]});
        chk("resp_data", {32'b0, (d_valid ? d_rdata : i_rdata)}, {32'b0, e[31:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int sel, input logic [11:0] a, input logic [31:0] dd);
    pl_we = 1'b1; pl_sel = sel; pl_addr = a; pl_data = dd;
    step();
    pl_we = 1'b0;
  endtask

  task automatic wait_valid(input bit data_side, output int c);
    c = -1;
    for (int k = 0; k < 30; k++) begin
      if (c < 0) begin
        step();
        if ((data_side ? d_valid : i_valid) === 1'b1) c = cyc;
      end
    end
  endtask

  task automatic wait_men(output int c);
    c = -1;
    for (int k = 0; k < 12; k++) begin
      if (c < 0) begin
        step();
        if (m_en[0] === 1'b1) c = cyc;
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t0, c, c1, c5, we_cnt;
    logic [9:0] busy_vec;
    logic [5:0] own_exp;
    int st_exp [6];
    own_exp = 6'b101111;
    st_exp  = '{1, 2, 3, 4, 0, 1};

    step();
    preload(0, 12'h010, 32'h0050_0093);
    preload(0, 12'h100, 32'h1122_3344);
    preload(0, 12'h020, 32'hCAFE_0001);
    preload(0, 12'h104, 32'h0000_0000);
    preload(0, 12'h030, 32'h3333_3333);
    preload(1, 12'h010, 32'h0050_0093);
    preload(2, 12'h010, 32'h0050_0093);

    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_owner", {63'b0, owner}, 64'd0);
    chk("rst_irdata", {32'b0, i_rdata}, 64'd0);
    chk("rst_drdata", {32'b0, d_rdata}, 64'd0);
    chk("rst_starve", {60'b0, dbg_starve}, 64'd0);

    // Test 1: fetch held across reset release.
    i_req = 1'b1; i_addr = 12'h010;
    step(); chk("t1_men_in_rst_a", {63'b0, m_en[0]}, 64'd0);
    step(); chk("t1_men_in_rst_b", {63'b0, m_en[0]}, 64'd0);
    rst = 1'b0;
    t0 = cyc;
    exp_q.push_back({1'b0, 32'h0050_0093});
    step();
    chk("t1_men", {63'b0, m_en[0]}, 64'd1);
    chk("t1_maddr", {52'b0, m_addr[0]}, 64'h010);
    chk("t1_mbe", {60'b0, m_be[0]}, 64'hF);
    chk("t1_mwe", {63'b0, m_we[0]}, 64'd0);
    wait_valid(1'b0, c);
    i_req = 1'b0;
    chk("t1_ivalid_cyc", 64'(c - t0), 64'd4);
    chk("t1_irdata", {32'b0, i_rdata}, 64'h0050_0093);

    // Test 2: simultaneous fetch and load; data first.
    step();
    i_req = 1'b1; i_addr = 12'h020;
    d_req = 1'b1; d_we = 1'b0; d_addr = 12'h100; d_be = 4'hF;
    t0 = cyc;
    exp_q.push_back({1'b1, 32'h1122_3344});
    exp_q.push_back({1'b0, 32'hCAFE_0001});
    busy_vec = '0;
    for (int k = 1; k <= 9; k++) begin
      step();
      busy_vec[k] = busy;
      if (k == 1) begin
        chk("t2_d_issue", {62'b0, m_en[0], owner}, 64'd3);
        chk("t2_d_addr", {52'b0, m_addr[0]}, 64'h100);
      end
      if (k == 4) begin
        chk("t2_dvalid", {63'b0, d_valid}, 64'd1);
        d_req = 1'b0;
      end
      if (k == 6) begin
        chk("t2_i_issue", {62'b0, m_en[0], owner}, 64'd2);
        chk("t2_i_addr", {52'b0, m_addr[0]}, 64'h020);
      end
      if (k == 9) begin
        chk("t2_ivalid", {63'b0, i_valid}, 64'd1);
        i_req = 1'b0;
      end
    end
    chk("t2_busy_pattern", {54'b0, busy_vec}, 64'h3DE);

    // Test 3: partial store, then a held request turns into a load.
    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 12'h104; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    t0 = cyc;
    exp_q.push_back({1'b1, 32'h1122_3344});
    we_cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (m_we[0] === 1'b1 && m_be[0] === 4'b0011) we_cnt++;
      if (k == 1) begin
        chk("t3_st_wdata", {32'b0, m_wdata[0]}, 64'hDEAD_BEEF);
        d_addr = 12'h200; d_wdata = 32'h0;
      end
      if (k == 4) begin
        chk("t3_st_dvalid", {63'b0, d_valid}, 64'd1);
        d_we = 1'b0; d_addr = 12'h104; d_be = 4'hF;
        exp_q.push_back({1'b1, 32'h0000_BEEF});
      end
    end
    chk("t3_we_cycles", 64'(we_cnt), 64'd1);
    wait_valid(1'b1, c);
    d_req = 1'b0;
    chk("t3_ld_cyc", 64'(c - t0), 64'd9);
    chk("t3_ld_data", {32'b0, d_rdata}, 64'h0000_BEEF);

    // Test 4: both requests held; fetch forced after STARVE_MAX data grants.
    step();
    i_req = 1'b1; i_addr = 12'h030;
    d_req = 1'b1; d_we = 1'b0; d_addr = 12'h100;
    for (int g = 0; g < 6; g++) begin
      exp_q.push_back(own_exp[g] ? {1'b1, 32'h1122_3344} : {1'b0, 32'h3333_3333});
    end
    for (int g = 0; g < 6; g++) begin
      wait_men(c);
      chk("t4_grant_seen", {63'b0, m_en[0]}, 64'd1);
      chk("t4_owner", {63'b0, owner}, {63'b0, own_exp[g]});
      chk("t4_starve", {60'b0, dbg_starve}, 64'(st_exp[g]));
    end
    i_req = 1'b0; d_req = 1'b0;
    wait_valid(1'b1, c);
    chk("t4_last_dvalid", {63'b0, d_valid}, 64'd1);

    // Test 5: reset while a load is in WAIT.
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 12'h104;
    step();
    d_req = 1'b0;
    chk("t5_issue", {63'b0, m_en[0]}, 64'd1);
    step();
    rst = 1'b1;
    step();
    chk("t5_state_idle", {62'b0, dbg_state}, 64'd0);
    chk("t5_men", {63'b0, m_en[0]}, 64'd0);
    chk("t5_busy", {63'b0, busy}, 64'd0);
    chk("t5_drdata", {32'b0, d_rdata}, 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) step();
    chk("t5_drdata_after", {32'b0, d_rdata}, 64'd0);

    // Test 6: latency 1 and 5 systems, request dropped before VALID.
    a_req = 1'b1; a_addr = 12'h010; a_rst = 1'b0;
    t0 = cyc;
    c1 = -1; c5 = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) a_req = 1'b0;
      if (iv[1] === 1'b1 && c1 < 0) c1 = k;
      if (iv[2] === 1'b1 && c5 < 0) c5 = k;
    end
    chk("t6_lat1_cyc", 64'(c1), 64'd3);
    chk("t6_lat5_cyc", 64'(c5), 64'd7);
    chk("t6_lat1_data", {32'b0, ird[1]}, 64'h0050_0093);
    chk("t6_lat5_data", {32'b0, ird[2]}, 64'h0050_0093);

    chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
